// File: rtl/score_display_scan_if.sv
// score_display_scan_if: score load request and scanned digit outputs of the score display feeder
interface score_display_scan_if #(parameter int BIN_W = 14);
    logic [BIN_W-1:0] score_in;
    logic             score_load;
    logic             busy;
    logic [3:0]       bcd_out;
    logic [3:0]       digit_en;
    modport master(output score_in, score_load, input busy, bcd_out, digit_en);
    modport slave(input score_in, score_load, output busy, bcd_out, digit_en);
endinterface

// File: rtl/score_display_scan.sv
// score_display_scan: binary score to BCD via double-dabble, leading-zero blanking, 4-digit scan
module score_display_scan #(
    parameter int BIN_W    = 14,
    parameter int SCAN_DIV = 100000
) (
    input logic                 clk,
    input logic                 rst,
    score_display_scan_if.slave bus
);
    localparam int CW = $clog2(BIN_W + 1);
    localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
    state_t state, state_nxt;
    logic [CW-1:0] bit_cnt;
    logic [BIN_W-1:0] sat, pend_val, src, src_sat;
    logic pending, start, wrap;
    logic [15:0] acc, adj, display_reg;
    logic [SW-1:0] scan_cnt;
    logic [1:0] idx, idx_nxt;
    logic [3:0] blank;
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        start = state == IDLE && (bus.score_load || pending);
        state_nxt = state == IDLE ? (start ? SHIFT : IDLE) :
                    state == SHIFT ? (bit_cnt == CW'(BIN_W - 1) ? COMMIT : SHIFT) : IDLE;
    end
    always_comb bus.busy = state != IDLE;
    // a fresh request in IDLE is newer than anything left pending
    always_comb begin
        src = bus.score_load ? bus.score_in : pend_val;
        src_sat = 32'(src) > 32'd9999 ? BIN_W'(9999) : src;
        adj = acc;
        for (int i = 0; i < 4; i++)
            adj[4*i +: 4] = acc[4*i +: 4] >= 4'd5 ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
            pend_val <= '0;
            sat <= '0;
            acc <= '0;
            bit_cnt <= '0;
            display_reg <= '0;
        end else begin
            if (start) begin
                sat <= src_sat;
                acc <= '0;
                bit_cnt <= '0;
                pending <= 1'b0;
            end else if (state == SHIFT) begin
                acc <= {adj[14:0], sat[BIN_W-1]};
                sat <= {sat[BIN_W-2:0], 1'b0};
                bit_cnt <= bit_cnt + CW'(1);
            end else if (state == COMMIT) begin
                display_reg <= acc;
            end
            if (state != IDLE && bus.score_load) begin
                pending <= 1'b1;
                pend_val <= bus.score_in;
            end
        end
    end
    always_comb begin
        wrap = scan_cnt == SW'(SCAN_DIV - 1);
        idx_nxt = idx + 2'd1;
        blank[0] = 1'b0;
        blank[3] = display_reg[15:12] == 4'd0;
        blank[2] = blank[3] && display_reg[11:8] == 4'd0;
        blank[1] = blank[2] && display_reg[7:4] == 4'd0;
    end
    // anode and nibble move together on the slot boundary so no digit ghosts
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            idx <= 2'd0;
            bus.digit_en <= 4'b1110;
            bus.bcd_out <= 4'h0;
        end else begin
            scan_cnt <= wrap ? '0 : scan_cnt + SW'(1);
            if (wrap) begin
                idx <= idx_nxt;
                bus.digit_en <= ~(4'b0001 << idx_nxt);
                bus.bcd_out <= blank[idx_nxt] ? 4'hF : display_reg[4*idx_nxt +: 4];
            end
        end
    end
endmodule

// File: tb/tb_score_display_scan.sv
// tb_score_display_scan: randomized and directed checks of conversion, blanking and scan against a decimal model
module tb_score_display_scan;
    localparam int BIN_W = 14;
    localparam int SCAN_DIV = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    always #5 clk = ~clk;
    score_display_scan_if #(.BIN_W(BIN_W)) bus();
    score_display_scan #(.BIN_W(BIN_W), .SCAN_DIV(SCAN_DIV)) dut(.clk(clk), .rst(rst), .bus(bus));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int val);
        bus.score_in = BIN_W'(val);
        bus.score_load = 1'b1;
        step();
        bus.score_load = 1'b0;
    endtask

    task automatic conv_len(output int n);
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            step();
        end
    endtask

    // expected digit k: decimal digit of min(raw,9999), blank above the leading nonzero digit
    task automatic check_display(input int raw, input string tag);
        int v;
        int p;
        int n;
        logic [3:0] prev, ed, eb;
        v = raw > 9999 ? 9999 : raw;
        n = 0;
        prev = bus.digit_en;
        step();
        while (!(bus.digit_en == 4'b1110 && prev != 4'b1110) && n < 40) begin
            prev = bus.digit_en;
            step();
            n++;
        end
        if (n >= 40) begin
            total++;
            bad++;
            $display("FAIL %s slot0 wait timeout digit_en=%b", tag, bus.digit_en);
            return;
        end
        p = 1;
        for (int k = 0; k < 4; k++) begin
            ed = ~(4'b0001 << k);
            eb = (k != 0 && v < p) ? 4'hF : 4'((v / p) % 10);
            total++;
            if (bus.digit_en !== ed) begin
                bad++;
                $display("FAIL %s digit_en slot%0d got=%b exp=%b", tag, k, bus.digit_en, ed);
            end
            total++;
            if (bus.bcd_out !== eb) begin
                bad++;
                $display("FAIL %s bcd_out digit%0d got=%h exp=%h (value %0d)", tag, k, bus.bcd_out, eb, v);
            end
            p *= 10;
            repeat (SCAN_DIV) step();
        end
    endtask

    task automatic load_and_check(input int val, input string tag);
        int n;
        do_load(val);
        conv_len(n);
        total++;
        if (n !== BIN_W + 1) begin
            bad++;
            $display("FAIL %s busy_len got=%0d exp=%0d", tag, n, BIN_W + 1);
        end
        check_display(val, tag);
    endtask

    task automatic test_reset();
        int s;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int n = 0; n < 16; n++) begin
            s = (n / SCAN_DIV) % 4;
            total++;
            if (bus.digit_en !== ~(4'b0001 << s) || bus.bcd_out !== (s == 0 ? 4'h0 : 4'hF) || bus.busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_scan cyc%0d got en=%b bcd=%h busy=%b exp en=%b bcd=%h busy=0",
                         n, bus.digit_en, bus.bcd_out, bus.busy, ~(4'b0001 << s), (s == 0 ? 4'h0 : 4'hF));
            end
            step();
        end
    endtask

    task automatic test_convert();
        load_and_check(2048, "convert_2048");
    endtask

    task automatic test_blanking();
        load_and_check(8, "blank_8");
        load_and_check(0, "blank_0");
        load_and_check(100, "blank_100");
        load_and_check(9, "blank_9");
        load_and_check(1000, "blank_1000");
    endtask

    task automatic test_saturate();
        load_and_check(12345, "sat_12345");
        load_and_check(16383, "sat_max");
        load_and_check(9999, "sat_9999");
    endtask

    task automatic test_back_to_back();
        int n, g, extra;
        do_load(16);
        repeat (3) step();
        do_load(32);
        repeat (2) step();
        do_load(64);
        conv_len(n);
        g = 0;
        while (!bus.busy && g < 20) begin
            g++;
            step();
        end
        total++;
        if (g !== 1) begin
            bad++;
            $display("FAIL b2b idle_gap got=%0d exp=1", g);
        end
        conv_len(n);
        total++;
        if (n !== BIN_W + 1) begin
            bad++;
            $display("FAIL b2b second_busy_len got=%0d exp=%0d", n, BIN_W + 1);
        end
        extra = 0;
        repeat (40) begin
            if (bus.busy) extra++;
            step();
        end
        total++;
        if (extra !== 0) begin
            bad++;
            $display("FAIL b2b extra_conversion busy_cycles got=%0d exp=0", extra);
        end
        check_display(64, "b2b_final");
    endtask

    task automatic test_mid_reset();
        load_and_check(512, "midrst_512");
        do_load(2048);
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if (bus.busy !== 1'b0 || bus.digit_en !== 4'b1110 || bus.bcd_out !== 4'h0) begin
            bad++;
            $display("FAIL midrst_state got busy=%b en=%b bcd=%h exp busy=0 en=1110 bcd=0",
                     bus.busy, bus.digit_en, bus.bcd_out);
        end
        check_display(0, "midrst_cleared");
        load_and_check(7, "midrst_7");
    endtask

    task automatic test_random();
        int v;
        for (int i = 0; i < 8; i++) begin
            v = (i % 2 == 0) ? int'($urandom_range(0, 999)) : int'($urandom_range(0, (1 << BIN_W) - 1));
            load_and_check(v, $sformatf("rand%0d_%0d", i, v));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.score_in = '0;
        bus.score_load = 1'b0;
        test_reset();
        test_convert();
        test_blanking();
        test_saturate();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
